// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned WordWidth = 32;
  localparam int unsigned CntWidth  = 16;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHdr0 = 3'd1,
    StHdr1 = 3'd2,
    StData = 3'd3,
    StCsum = 3'd4,
    StErr  = 3'd5
  } loader_state_e;

  // Word index to IMEM byte address.
  function automatic logic [WordWidth-1:0] word_addr(input logic [WordWidth-3:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in and IMEM write port out; master is the loader side.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned W = WordWidth
);
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed byte-stream program image into IMEM as 32-bit words and holds
// the CPU until the image is written and its XOR checksum verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ImemSize = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_hold
);

  localparam int unsigned AW = $clog2(ImemSize);

  loader_state_e         state;
  logic [AW-1:0]         idx;
  logic [1:0]            lane;
  logic [7:0]            csum;
  logic [23:0]           sh;
  logic [CntWidth-1:0]   cnt;
  logic [CntWidth-1:0]   hdr_n;
  logic                  xfer;
  logic                  last_word;
  logic                  active;

  always_comb begin
    active = (state == StHdr0) || (state == StHdr1) || (state == StData) ||
             (state == StCsum);
  end

  assign bus.in_ready = active;
  assign busy         = active;
  assign cpu_hold     = active | err;
  assign xfer         = active & bus.in_valid;
  assign hdr_n        = {bus.in_data, cnt[7:0]};
  assign last_word    = (CntWidth'(idx) == (cnt - CntWidth'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      idx           <= '0;
      lane          <= '0;
      csum          <= '0;
      sh            <= '0;
      cnt           <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      case (state)
        StIdle, StErr: begin
          if (start) begin
            err   <= 1'b0;
            idx   <= '0;
            lane  <= '0;
            csum  <= '0;
            state <= StHdr0;
          end
        end
        StHdr0: begin
          if (xfer) begin
            cnt[7:0] <= bus.in_data;
            state    <= StHdr1;
          end
        end
        StHdr1: begin
          if (xfer) begin
            cnt[15:8] <= bus.in_data;
            // Oversized images are rejected before any write can wrap the index.
            if (hdr_n > CntWidth'(ImemSize)) begin
              err   <= 1'b1;
              state <= StErr;
            end else if (hdr_n == '0) begin
              state <= StCsum;
            end else begin
              state <= StData;
            end
          end
        end
        StData: begin
          if (xfer) begin
            csum <= csum ^ bus.in_data;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= {bus.in_data, sh};
              bus.mem_addr  <= word_addr((WordWidth-2)'(idx));
              idx           <= idx + AW'(1);
              if (last_word) begin
                state <= StCsum;
              end
            end else begin
              // First byte ends up in the LSBs after three right shifts.
              sh <= {bus.in_data, sh[23:8]};
            end
          end
        end
        StCsum: begin
          if (xfer) begin
            if (bus.in_data == csum) begin
              done  <= 1'b1;
              state <= StIdle;
            end else begin
              err   <= 1'b1;
              state <= StErr;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
